pipeline_step_ctrl: RTL and testbench
=====================================

PIPELINE_STEP_CTRL -- requirements
Module: pipeline_step_ctrl

Interface
REQ-001 SHALL have parameter BITS_SIZE, default 32: width of cycle counter.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 4: o_step cycles issued after HALT detection to empty the pipeline (IF/ID through MEM/WB).
REQ-003 SHALL have parameter CNT_W, default 3: width of drain counter; CNT_W SHALL hold DRAIN_CYCLES.
REQ-004 SHALL have port i_clk input 1: clock; all state changes on rising edge.
REQ-005 SHALL have port i_reset input 1: synchronous, active-high.
REQ-006 SHALL have port i_cmd_valid input 1: debug command present.
REQ-007 SHALL have port i_cmd input 2: 00 NOP, 01 RUN, 10 STEP, 11 STOP.
REQ-008 SHALL have port o_cmd_ready output 1: command accepted on the edge where i_cmd_valid & o_cmd_ready.
REQ-009 SHALL have port i_halt input 1: HALT instruction present at IF (decoded by fetch).
REQ-010 SHALL have port o_step output 1: pipeline advance enable to every pipeline register (IF/ID step input) and PC.
REQ-011 SHALL have port o_state output 3: current FSM state encoding.
REQ-012 SHALL have port o_cycle_count output BITS_SIZE: number of cycles with o_step=1.
REQ-013 SHALL have port o_done output 1: single-cycle pulse on entry to DONE.

Function
REQ-014 SHALL implement FSM states IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4.
REQ-015 o_step SHALL be Moore-decoded: 1 in RUN, STEP, DRAIN; 0 in IDLE, DONE.
REQ-016 o_cmd_ready SHALL be 1 in IDLE and RUN, 0 in STEP, DRAIN, DONE.
REQ-017 IDLE: accepted RUN -> RUN; accepted STEP -> STEP; NOP and STOP -> stay IDLE.
REQ-018 RUN: accepted STOP -> IDLE; RUN, STEP, NOP -> stay RUN.
REQ-019 STEP: lasts exactly one cycle, then -> IDLE.
REQ-020 i_halt SHALL be sampled only when o_step=1; in RUN or STEP, i_halt=1 -> DRAIN with drain counter loaded to DRAIN_CYCLES.
REQ-021 i_halt=1 with accepted STOP in RUN: halt wins -> DRAIN.
REQ-022 DRAIN: counter decrements each cycle; DRAIN SHALL last exactly DRAIN_CYCLES cycles, then -> DONE; i_halt ignored.
REQ-023 DONE: terminal until i_reset; o_done=1 only in first DONE cycle.
REQ-024 Latency: command accepted at edge N -> o_step reflects new state in cycle after edge N (one cycle).
REQ-025 o_cycle_count SHALL increment by 1 each cycle o_step=1; SHALL saturate at all-ones, no wrap.
REQ-026 Commands presented while o_cmd_ready=0 SHALL be ignored, not queued.

Reset
REQ-027 i_reset SHALL force state IDLE, o_step=0, o_cmd_ready=1, o_cycle_count=0, o_done=0, drain counter=0.
REQ-028 Reset mid-RUN or mid-DRAIN SHALL take effect on the same edge, overriding any command or i_halt.

Structure
REQ-029 State encodings and command encodings SHALL be localparams in the shared debug-unit include file, reused by the UART debug front end.
REQ-030 One sub-module sat_counter (parameterised width, enable, sync reset, saturating) SHALL implement o_cycle_count; drain counter is inline.

Verification
REQ-031 Reset, then STEP x3 from IDLE -> three isolated single-cycle o_step pulses, o_cycle_count=3, state IDLE after each.
REQ-032 RUN, hold 10 cycles, STOP -> o_step high 10 cycles starting cycle after RUN accept, o_cycle_count=10, state IDLE.
REQ-033 RUN, i_halt at cycle 5 of RUN -> DRAIN 4 cycles, o_done pulse one cycle, o_cycle_count=9, o_cmd_ready=0, STEP then ignored.
REQ-034 RUN with i_halt and STOP asserted on same edge -> DRAIN entered, not IDLE.
REQ-035 BITS_SIZE=4, RUN 20 cycles -> o_cycle_count saturates at 15.
REQ-036 i_reset during DRAIN cycle 2 -> next cycle IDLE, o_step=0, o_cycle_count=0, no o_done.

Source files
------------

// File: rtl/pipeline_step_ctrl_pkg.sv
// Shared debug-unit definitions: run-control state and command encodings.
// Latency: n/a (constants, types and a pure decode function only).
// Backpressure: n/a.
package pipeline_step_ctrl_pkg;

    // Debug command encodings, also decoded by the UART debug front end.
    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_STOP = 2'b11;

    // Run-control state encodings, visible to the host through o_state.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // States in which the pipeline is allowed to advance.
    function automatic logic state_advances(input state_t st);
        return (st == ST_RUN) || (st == ST_STEP) || (st == ST_DRAIN);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
// Latency: count reflects an enabled cycle on the following rising edge.
// Backpressure: none; enable is sampled every cycle.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Increment on enable unless already at the ceiling, so the count never wraps.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_step_ctrl.sv
// Debug run-control: RUN/STEP/STOP commands gate the pipeline step enable; HALT drains the pipe.
// Latency: accepted command or sampled halt changes o_step one cycle later (Moore outputs).
// Backpressure: o_cmd_ready low in STEP/DRAIN/DONE; commands offered then are dropped, not queued.
module pipeline_step_ctrl
    import pipeline_step_ctrl_pkg::*;
#(
    parameter int BITS_SIZE    = 32,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 3
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_cmd_valid,
    input  logic [1:0]           i_cmd,
    output logic                 o_cmd_ready,
    input  logic                 i_halt,
    output logic                 o_step,
    output logic [2:0]           o_state,
    output logic [BITS_SIZE-1:0] o_cycle_count,
    output logic                 o_done
);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   drain_cnt_q;
    logic [CNT_W-1:0]   drain_cnt_d;
    logic               done_q;
    logic               done_d;
    logic               cmd_acc;

    // Handshake completes only while the FSM is willing to take a command.
    assign cmd_acc = i_cmd_valid && o_cmd_ready;

    // Moore output decode from the current state.
    always_comb begin
        o_step      = state_advances(state_q);
        o_cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
    end

    // Next-state logic; halt takes priority over any command because it is a
    // property of the instruction stream, not a host request.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_acc && (i_cmd == CMD_RUN)) begin
                    state_d = ST_RUN;
                end else if (cmd_acc && (i_cmd == CMD_STEP)) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (i_halt) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = CNT_W'(DRAIN_CYCLES);
                end else if (cmd_acc && (i_cmd == CMD_STOP)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (i_halt) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = CNT_W'(DRAIN_CYCLES);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // The counter holds the drain cycles still owed including this one.
                drain_cnt_d = (drain_cnt_q == '0) ? '0 : drain_cnt_q - CNT_W'(1);
                if (drain_cnt_q <= CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    // State, drain counter and done pulse registers; reset overrides everything.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            done_q      <= done_d;
        end
    end

    assign o_state = state_q;
    assign o_done  = done_q;

    sat_counter #(
        .WIDTH (BITS_SIZE)
    ) u_cycle_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .en      (o_step),
        .count   (o_cycle_count)
    );

endmodule

// File: tb/tb_pipeline_step_ctrl.sv
module tb_pipeline_step_ctrl;

    localparam logic [1:0] C_NOP  = 2'b00;
    localparam logic [1:0] C_RUN  = 2'b01;
    localparam logic [1:0] C_STEP = 2'b10;
    localparam logic [1:0] C_STOP = 2'b11;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_STEP  = 2;
    localparam int S_DRAIN = 3;
    localparam int S_DONE  = 4;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic        halt;
    logic        rdy32, step32, done32;
    logic [2:0]  st32;
    logic [31:0] cnt32;
    logic        rdy4, step4, done4;
    logic [2:0]  st4;
    logic [3:0]  cnt4;

    int checks   = 0;
    int failures = 0;

    pipeline_step_ctrl dut32 (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_cmd_valid   (cmd_valid),
        .i_cmd         (cmd),
        .o_cmd_ready   (rdy32),
        .i_halt        (halt),
        .o_step        (step32),
        .o_state       (st32),
        .o_cycle_count (cnt32),
        .o_done        (done32)
    );

    pipeline_step_ctrl #(.BITS_SIZE(4)) dut4 (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_cmd_valid   (cmd_valid),
        .i_cmd         (cmd),
        .o_cmd_ready   (rdy4),
        .i_halt        (halt),
        .o_step        (step4),
        .o_state       (st4),
        .o_cycle_count (cnt4),
        .o_done        (done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst;
        logic       v;
        logic [1:0] cmd;
        logic       halt;
        logic       step;
        logic       rdy;
        int         st;
        int         cnt;
        logic       done;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic r, input logic v, input logic [1:0] c, input logic h,
                                input logic s, input logic rd, input int st, input int cn,
                                input logic d);
        vec_t x;
        x.rst = r; x.v = v; x.cmd = c; x.halt = h;
        x.step = s; x.rdy = rd; x.st = st; x.cnt = cn; x.done = d;
        return x;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, then sample just after the rising edge.
    task automatic cyc(input logic r, input logic v, input logic [1:0] c, input logic h);
        @(negedge clk);
        rst = r; cmd_valid = v; cmd = c; halt = h;
        @(posedge clk);
        #1;
    endtask

    int steps;
    int drains;
    int dones;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd = C_NOP; halt = 1'b0;

        //            rst v  cmd     h  | step rdy st       cnt done
        vecs[0]  = mk(1, 0, C_NOP,  0,   0, 1, S_IDLE,  0,  0);
        vecs[1]  = mk(0, 1, C_STEP, 0,   1, 0, S_STEP,  0,  0);
        vecs[2]  = mk(0, 0, C_NOP,  0,   0, 1, S_IDLE,  1,  0);
        vecs[3]  = mk(0, 1, C_STEP, 0,   1, 0, S_STEP,  1,  0);
        vecs[4]  = mk(0, 1, C_STEP, 0,   0, 1, S_IDLE,  2,  0); // offered while not ready
        vecs[5]  = mk(0, 1, C_STEP, 0,   1, 0, S_STEP,  2,  0);
        vecs[6]  = mk(0, 0, C_NOP,  0,   0, 1, S_IDLE,  3,  0);
        vecs[7]  = mk(0, 1, C_NOP,  0,   0, 1, S_IDLE,  3,  0);
        vecs[8]  = mk(0, 1, C_STOP, 0,   0, 1, S_IDLE,  3,  0);
        vecs[9]  = mk(0, 0, C_RUN,  0,   0, 1, S_IDLE,  3,  0); // not valid
        vecs[10] = mk(0, 1, C_RUN,  0,   1, 1, S_RUN,   3,  0);
        vecs[11] = mk(0, 1, C_STEP, 0,   1, 1, S_RUN,   4,  0);
        vecs[12] = mk(0, 1, C_NOP,  0,   1, 1, S_RUN,   5,  0);
        vecs[13] = mk(0, 1, C_STOP, 0,   0, 1, S_IDLE,  6,  0);
        vecs[14] = mk(0, 0, C_NOP,  0,   0, 1, S_IDLE,  6,  0);
        vecs[15] = mk(0, 1, C_RUN,  0,   1, 1, S_RUN,   6,  0);
        vecs[16] = mk(0, 1, C_STOP, 1,   1, 0, S_DRAIN, 7,  0); // halt beats STOP
        vecs[17] = mk(0, 0, C_NOP,  1,   1, 0, S_DRAIN, 8,  0); // halt ignored in drain
        vecs[18] = mk(0, 0, C_NOP,  0,   1, 0, S_DRAIN, 9,  0);
        vecs[19] = mk(0, 0, C_NOP,  0,   1, 0, S_DRAIN, 10, 0);
        vecs[20] = mk(0, 0, C_NOP,  0,   0, 0, S_DONE,  11, 1);
        vecs[21] = mk(0, 1, C_STEP, 0,   0, 0, S_DONE,  11, 0);
        vecs[22] = mk(0, 1, C_RUN,  0,   0, 0, S_DONE,  11, 0);
        vecs[23] = mk(1, 0, C_NOP,  0,   0, 1, S_IDLE,  0,  0);
        vecs[24] = mk(0, 1, C_STEP, 0,   1, 0, S_STEP,  0,  0);
        vecs[25] = mk(0, 0, C_NOP,  1,   1, 0, S_DRAIN, 1,  0); // halt during STEP
        vecs[26] = mk(0, 0, C_NOP,  0,   1, 0, S_DRAIN, 2,  0);
        vecs[27] = mk(1, 1, C_RUN,  1,   0, 1, S_IDLE,  0,  0); // reset mid-drain wins
        vecs[28] = mk(0, 0, C_NOP,  0,   0, 1, S_IDLE,  0,  0);
        vecs[29] = mk(0, 0, C_NOP,  1,   0, 1, S_IDLE,  0,  0); // halt ignored in IDLE

        for (int i = 0; i < NV; i++) begin
            cyc(vecs[i].rst, vecs[i].v, vecs[i].cmd, vecs[i].halt);
            chk($sformatf("vec%0d step", i),  int'(step32), int'(vecs[i].step));
            chk($sformatf("vec%0d ready", i), int'(rdy32),  int'(vecs[i].rdy));
            chk($sformatf("vec%0d state", i), int'(st32),   vecs[i].st);
            chk($sformatf("vec%0d count", i), int'(cnt32),  vecs[i].cnt);
            chk($sformatf("vec%0d done", i),  int'(done32), int'(vecs[i].done));
            chk($sformatf("vec%0d count4", i), int'(cnt4),  vecs[i].cnt);
        end

        // RUN held for 10 cycles, STOP accepted in the 10th.
        cyc(1, 0, C_NOP, 0);
        cyc(0, 1, C_RUN, 0);
        chk("run10 entry state", int'(st32), S_RUN);
        steps = 0;
        for (int i = 0; i < 10; i++) begin
            steps += int'(step32);
            cyc(0, (i == 9), C_STOP, 0);
        end
        chk("run10 step cycles", steps, 10);
        chk("run10 step after stop", int'(step32), 0);
        chk("run10 state", int'(st32), S_IDLE);
        chk("run10 count", int'(cnt32), 10);
        chk("run10 count4", int'(cnt4), 10);

        // HALT seen in the 5th RUN cycle: 4-cycle drain, one done pulse.
        cyc(1, 0, C_NOP, 0);
        cyc(0, 1, C_RUN, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, C_NOP, (i == 4));
        chk("halt drain entry", int'(st32), S_DRAIN);
        drains = 0;
        dones  = 0;
        for (int k = 0; k < 20 && int'(st32) == S_DRAIN; k++) begin
            drains++;
            dones += int'(done32);
            cyc(0, 0, C_NOP, 0);
        end
        chk("halt drain cycles", drains, 4);
        chk("halt done during drain", dones, 0);
        chk("halt state done", int'(st32), S_DONE);
        chk("halt done pulse", int'(done32), 1);
        chk("halt count", int'(cnt32), 9);
        chk("halt ready", int'(rdy32), 0);
        cyc(0, 1, C_STEP, 0);
        chk("done step ignored state", int'(st32), S_DONE);
        chk("done step ignored step", int'(step32), 0);
        chk("done pulse cleared", int'(done32), 0);
        chk("done count held", int'(cnt32), 9);

        // 20 RUN cycles: 4-bit counter saturates, 32-bit keeps counting.
        cyc(1, 0, C_NOP, 0);
        cyc(0, 1, C_RUN, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, C_NOP, 0);
        chk("sat count4", int'(cnt4), 15);
        chk("sat count32", int'(cnt32), 20);
        cyc(0, 1, C_STOP, 0);
        chk("sat count4 held", int'(cnt4), 15);
        chk("sat stop state", int'(st4), S_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
